wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters.
  - Port A: the main pipeline W stage, which supplies the 5-bit destination already chosen by the rt/rd select mux.
  - Port B: the multi-cycle mult/div unit writing back mflo/mfhi-style results.
- Arbitrates with fixed priority to A, registers the winning address and data, and drops writes to register 0.
- Sits between the W-stage pipeline register and the register file write port.

---
 rtl/wb_port_arbiter.sv | 82 ++++++++
 tb/tb_wb_port_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: fixed priority to the W stage (A) over mult/div (B), registered write, r0 dropped.
// Optional B starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_port_arbiter #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_src
);

  if (STARVE_LIMIT == 0) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  logic force_b;
  logic a_acc;
  logic b_acc;

`ifdef WB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt;

  // Counts consecutive cycles B sat blocked; at the limit B owns the port for one cycle.
  assign force_b = (wait_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!b_valid || b_ready) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign force_b = 1'b0;
`endif

  // Readys depend only on valids, reset and the wait counter, never on rf_*.
  assign a_ready = !reset && !force_b;
  assign b_ready = !reset && (force_b || !a_valid);

  assign a_acc = a_valid && a_ready;
  assign b_acc = b_valid && b_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      rf_src   <= 1'b0;
    end else if (a_acc) begin
      rf_we    <= (a_addr != '0);
      rf_addr  <= a_addr;
      rf_wdata <= a_data;
      rf_src   <= 1'b0;
    end else if (b_acc) begin
      rf_we    <= (b_addr != '0);
      rf_addr  <= b_addr;
      rf_wdata <= b_data;
      rf_src   <= 1'b1;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios plus randomized traffic against a cycle-level model.
module tb_wb_port_arbiter;
  localparam int LIMIT = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        rf_we, rf_src;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_src(rf_src)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        src;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mdl;
  exp_t        me;
  int unsigned mwait;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: B may only win when A is idle, or after LIMIT consecutive blocked cycles with the guard.
  task automatic cycle(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       output logic aacc, output logic bacc);
    logic force_b, ar, br;
    exp_t e;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    force_b = GUARD && (mwait == LIMIT);
    ar = !force_b;
    br = force_b || !av;
    chk("a_ready", a_ready, ar);
    chk("b_ready", b_ready, br);
    aacc = a_valid && a_ready;
    bacc = b_valid && b_ready;
    e = mdl;
    e.we = 1'b0;
    if (av && ar)      e = '{we: (aa != 5'd0), addr: aa, data: ad, src: 1'b0};
    else if (bv && br) e = '{we: (ba != 5'd0), addr: ba, data: bd, src: 1'b1};
    if (bv && !br) mwait = (mwait < LIMIT) ? mwait + 1 : mwait;
    else           mwait = 0;
    mdl = e;
    @(posedge clk);
    sbq.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && sbq.size() > 0) begin
      me = sbq.pop_front();
      chk("rf_we", rf_we, me.we);
      chk("rf_addr", rf_addr, me.addr);
      chk("rf_wdata", rf_wdata, me.data);
      chk("rf_src", rf_src, me.src);
    end
  end

  initial begin
    logic aa, ba;
    logic pav, pbv;
    logic [4:0] paa, pba, anext;
    logic [31:0] pad, pbd;
    int first;

    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    mdl = '{we: 1'b0, addr: 5'd0, data: 32'd0, src: 1'b0};
    mwait = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_we", rf_we, 0);
    chk("reset_addr", rf_addr, 0);
    chk("reset_wdata", rf_wdata, 0);
    chk("reset_src", rf_src, 0);

    repeat (10) cycle(0, 0, 0, 0, 0, 0, aa, ba);

    cycle(1, 5'd5, 32'h1234, 0, 0, 0, aa, ba);
    chk("a_only_accept", aa, 1);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, aa, ba);

    cycle(1, 5'd8, 32'hAAAA, 1, 5'd8, 32'hBBBB, aa, ba);
    chk("same_addr_a_acc", aa, 1);
    chk("same_addr_b_wait", ba, 0);
    cycle(0, 0, 0, 1, 5'd8, 32'hBBBB, aa, ba);
    chk("same_addr_b_acc", ba, 1);
    cycle(0, 0, 0, 0, 0, 0, aa, ba);

    cycle(1, 5'd0, 32'hFFFF, 0, 0, 0, aa, ba);
    chk("r0_consumed", aa, 1);
    cycle(0, 0, 0, 1, 5'd3, 32'h3333, aa, ba);
    chk("after_r0_b_acc", ba, 1);
    cycle(0, 0, 0, 0, 0, 0, aa, ba);

    first = -1;
    anext = 5'd1;
    for (int i = 0; i < 8; i++) begin
      cycle(1, anext, {27'd0, anext}, first < 0, 5'd9, 32'h9999, aa, ba);
      if (aa) anext = anext + 5'd1;
      if (ba && first < 0) first = i;
    end
    chk("starve_b_index", first, GUARD ? LIMIT : -1);
    if (first < 0) begin
      cycle(0, 0, 0, 1, 5'd9, 32'h9999, aa, ba);
      chk("starve_b_after_a_drop", ba, 1);
    end
    cycle(0, 0, 0, 0, 0, 0, aa, ba);

    cycle(1, 5'd7, 32'h7777, 0, 0, 0, aa, ba);
    #5;
    reset = 1'b1;
    #1;
    chk("async_rst_we", rf_we, 0);
    chk("async_rst_addr", rf_addr, 0);
    chk("async_rst_wdata", rf_wdata, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("no_accept_in_reset", rf_we, 0);
    reset = 1'b0;
    a_valid = 0;
    mdl = '{we: 1'b0, addr: 5'd0, data: 32'd0, src: 1'b0};
    mwait = 0;
    cycle(1, 5'd4, 32'h4444, 0, 0, 0, aa, ba);
    chk("post_rst_accept", aa, 1);
    cycle(0, 0, 0, 0, 0, 0, aa, ba);

    pav = 0; pbv = 0; paa = 0; pba = 0; pad = 0; pbd = 0;
    repeat (300) begin
      if (!pav && $urandom_range(3) != 0) begin
        pav = 1;
        paa = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
        pad = $urandom;
      end
      if (!pbv && $urandom_range(1) == 0) begin
        pbv = 1;
        pba = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
        pbd = $urandom;
      end
      cycle(pav, paa, pad, pbv, pba, pbd, aa, ba);
      if (aa) pav = 0;
      if (ba) pbv = 0;
    end
    repeat (2) cycle(0, 0, 0, 0, 0, 0, aa, ba);
    #10;
    chk("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
